// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Two-port round-robin arbiter and sequencer for one shared iterative
//   unsigned shift-add multiplier. Each accepted operand pair runs WIDTH
//   partial-product steps (one per clock); the 2*WIDTH-bit product is then
//   held until the owning requester takes it.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   req0_*       requester 0 operand handshake (valid/ready, m, q)
//   req1_*       requester 1 operand handshake (valid/ready, m, q)
//   rsp0_*       requester 0 product handshake (valid/ready)
//   rsp1_*       requester 1 product handshake (valid/ready)
//   rsp_product  product {A,Q}; meaningful only while a rsp valid is high
//   busy         high while a multiply is running or waiting to be taken
//   owner        id of the current or most recently granted requester
module mult_share_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_m,
  input  logic [WIDTH-1:0]   req0_q,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_m,
  input  logic [WIDTH-1:0]   req1_q,
  output logic               req1_ready,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               busy,
  output logic               owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic             c_reg;
  logic [CNT_W-1:0] count_reg;
  logic             owner_reg;

  logic             grant0;
  logic             grant1;
  logic             rsp_take;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // Grant is combinational in IDLE. Under contention the requester that
  // did not win last time is served, so owner resetting to 1 lets
  // requester 0 win the very first contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_reg == S_IDLE) begin
      grant0 = req0_valid && (!req1_valid || owner_reg);
      grant1 = req1_valid && (!req0_valid || !owner_reg);
    end
  end

  // Only the owner's ready can release DONE; the other side is ignored.
  assign rsp_take = owner_reg ? rsp1_ready : rsp0_ready;

  // {C,A} forms a WIDTH+1 bit accumulator so the carry out of the add
  // is shifted into A rather than dropped.
  assign addend = q_reg[0] ? m_reg : '0;
  assign sum    = {c_reg, a_reg} + {1'b0, addend};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      c_reg     <= 1'b0;
      count_reg <= '0;
      owner_reg <= 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant0 || grant1) begin
            a_reg     <= '0;
            c_reg     <= 1'b0;
            q_reg     <= grant1 ? req1_q : req0_q;
            m_reg     <= grant1 ? req1_m : req0_m;
            count_reg <= CNT_INIT;
            owner_reg <= grant1;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          // {C,A,Q} <= {0, c_n, s, Q} >> 1
          c_reg     <= 1'b0;
          a_reg     <= sum[WIDTH:1];
          q_reg     <= {sum[0], q_reg[WIDTH-1:1]};
          count_reg <= count_reg - CNT_LAST;
          if (count_reg == CNT_LAST) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_take) begin
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp0_valid  = (state_reg == S_DONE) && !owner_reg;
  assign rsp1_valid  = (state_reg == S_DONE) && owner_reg;
  assign rsp_product = {a_reg, q_reg};
  assign busy        = (state_reg != S_IDLE);
  assign owner       = owner_reg;

endmodule
